// File: rtl/maze_pkg.sv
// maze_pkg: shared widths, arbiter state encodings and read-owner IDs for the maze RAM.
package maze_pkg;
    localparam int MAZE_ADDR_W = 10;
    localparam int MAZE_DATA_W = 3;
    localparam int MAZE_DIM    = 32;
    typedef enum logic [2:0] {START, LOAD, DRAIN, RUN, DRAIN2} state_t;
    typedef enum logic {OWN_GM = 1'b0, OWN_DR = 1'b1} owner_t;
endpackage

// File: rtl/maze_rd_tag_pipe.sv
// maze_rd_tag_pipe: RD_LAT-deep {valid,owner} delay line tracking outstanding reads; clr drops every in-flight entry.
module maze_rd_tag_pipe
    import maze_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   clr,
    input  logic   in_valid,
    input  owner_t in_owner,
    output logic   out_valid,
    output owner_t out_owner
);
    logic [RD_LAT-1:0] valid;
    logic [RD_LAT-1:0] own;
    always_ff @(posedge clk) begin
        valid <= clr ? '0 : RD_LAT'({valid, in_valid});
        own   <= clr ? '0 : RD_LAT'({own, in_owner});
    end
    assign out_valid = valid[RD_LAT-1];
    assign out_owner = owner_t'(own[RD_LAT-1]);
endmodule

// File: rtl/maze_ram_arbiter.sv
// maze_ram_arbiter: shares the single-port maze RAM between loader, game and draw; sequences load -> run.
// MAZE_ARB_RR_EN selects round-robin game/draw arbitration instead of fixed priority with a draw starvation cap.
module maze_ram_arbiter
    import maze_pkg::*;
#(
    parameter int ADDR_W = MAZE_ADDR_W,
    parameter int DATA_W = MAZE_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              reload,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              ld_start,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [DATA_W-1:0] gm_wdata,
    output logic              gm_gnt,
    output logic              gm_rvalid,
    output logic [DATA_W-1:0] gm_rdata,
    input  logic              dr_req,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_gnt,
    output logic              dr_rvalid,
    output logic [DATA_W-1:0] dr_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q,
    output logic              maze_ready
);
    localparam logic [1:0] LAST = 2'(RD_LAT - 1);
    state_t state, next;
    logic [1:0] cnt;
    logic pv, in_valid, dr_win;
    owner_t po, in_owner;
    logic [DATA_W-1:0] gm_hold, dr_hold;
`ifdef MAZE_ARB_RR_EN
    logic prio_dr;
    assign dr_win = dr_req && (!gm_req || prio_dr);
`else
    logic [3:0] starve;
    assign dr_win = dr_req && (!gm_req || starve == 4'd8);
`endif
    assign in_valid = (gm_gnt && !gm_we) || dr_gnt;
    assign in_owner = dr_gnt ? OWN_DR : OWN_GM;
    maze_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk      (clk),
        .clr      (!resetn),
        .in_valid (in_valid),
        .in_owner (in_owner),
        .out_valid(pv),
        .out_owner(po)
    );
    // Read data passes straight through on the return cycle and is held in a register afterwards.
    assign gm_rvalid  = resetn && pv && po == OWN_GM;
    assign dr_rvalid  = resetn && pv && po == OWN_DR;
    assign gm_rdata   = gm_rvalid ? ram_q : gm_hold;
    assign dr_rdata   = dr_rvalid ? ram_q : dr_hold;
    assign maze_ready = state == RUN;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= START;
            cnt      <= '0;
            ld_start <= 1'b0;
            gm_hold  <= '0;
            dr_hold  <= '0;
`ifdef MAZE_ARB_RR_EN
            prio_dr  <= 1'b0;
`else
            starve   <= '0;
`endif
        end else begin
            state    <= next;
            cnt      <= next == state ? cnt + 2'd1 : '0;
            ld_start <= state == START;
            gm_hold  <= gm_rdata;
            dr_hold  <= dr_rdata;
`ifdef MAZE_ARB_RR_EN
            if (gm_gnt || dr_gnt) prio_dr <= gm_gnt;
`else
            starve   <= (dr_req && gm_gnt) ? starve + 4'd1 : '0;
`endif
        end
    end
    always_comb begin
        next      = state;
        gm_gnt    = 1'b0;
        dr_gnt    = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state)
            START:  next = LOAD;
            LOAD: begin
                ram_addr  = ld_addr;
                ram_we    = ld_valid;
                ram_wdata = ld_data;
                next      = ld_done ? DRAIN : LOAD;
            end
            DRAIN:  next = cnt == LAST ? RUN : DRAIN;
            RUN: begin
                dr_gnt    = dr_win;
                gm_gnt    = gm_req && !dr_win;
                ram_addr  = dr_win ? dr_addr : gm_gnt ? gm_addr : '0;
                ram_we    = gm_gnt && gm_we;
                ram_wdata = (gm_gnt && gm_we) ? gm_wdata : '0;
                next      = reload ? DRAIN2 : RUN;
            end
            DRAIN2: next = cnt == LAST ? START : DRAIN2;
            default: next = START;
        endcase
    end
endmodule

// File: tb/tb_maze_ram_arbiter.sv
// tb_maze_ram_arbiter: directed checks of load sequencing, arbitration, read return routing and reset/reload.
module tb_maze_ram_arbiter;
    import maze_pkg::*;
    localparam int AW = MAZE_ADDR_W;
    localparam int DW = MAZE_DATA_W;
`ifdef MAZE_ARB_RR_EN
    localparam logic [8:0] EXP_PAT = 9'h0AA;
`else
    localparam logic [8:0] EXP_PAT = 9'h100;
`endif
    logic clk = 1'b0, resetn = 1'b0, reload = 1'b0;
    logic ld_valid = 1'b0, ld_done = 1'b0, ld_start;
    logic [AW-1:0] ld_addr = '0, gm_addr = '0, dr_addr = '0, ram_addr;
    logic [DW-1:0] ld_data = '0, gm_wdata = '0, gm_rdata, dr_rdata, ram_wdata, ram_q;
    logic gm_req = 1'b0, gm_we = 1'b0, gm_gnt, gm_rvalid;
    logic dr_req = 1'b0, dr_gnt, dr_rvalid, ram_we, maze_ready;
    logic [DW-1:0] mem [MAZE_DIM*MAZE_DIM];
    logic [DW-1:0] q;
    int checks = 0, errors = 0, n_start = 0, n, bad;
    logic [8:0] pat;
    always #5 clk = ~clk;
    maze_ram_arbiter dut (
        .clk(clk), .resetn(resetn), .reload(reload),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done), .ld_start(ld_start),
        .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
        .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt), .dr_rvalid(dr_rvalid), .dr_rdata(dr_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q), .maze_ready(maze_ready)
    );
    // Single-port write-first RAM model, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        q <= ram_we ? ram_wdata : mem[ram_addr];
    end
    assign ram_q = q;
    always @(negedge clk) if (ld_start) n_start++;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        repeat (3) tick;
        chk("rst_ld_start", ld_start, 0);
        chk("rst_ready", maze_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_gm_rvalid", gm_rvalid, 0);
        chk("rst_dr_rdata", dr_rdata, 0);
        resetn = 1'b1;
        tick;
        for (int a = 0; a < 1024; a++) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(a);
            ld_data  = DW'(a);
            gm_req   = (a < 600);
            gm_addr  = 10'd5;
            #1;
            if (a == 0) chk("load_gm_gnt0", gm_gnt, 0);
            if (a == 512) chk("load_gm_gnt512", gm_gnt, 0);
            if (a == 700) chk("load_ram_addr", ram_addr, 700);
            tick;
        end
        ld_valid = 1'b0;
        gm_req   = 1'b0;
        ld_done  = 1'b1;
        n = 0;
        while (!maze_ready && n < 10) begin
            tick;
            n++;
        end
        ld_done = 1'b0;
        chk("ready_latency", n, 2);
        chk("ld_start_once", n_start, 1);
        bad = 0;
        for (int a = 0; a < 1024; a++) if (mem[a] !== DW'(a)) bad++;
        chk("ram_contents", bad, 0);
        chk("ram_1023", mem[1023], 7);
        dr_req  = 1'b1;
        dr_addr = 10'd33;
        #1;
        chk("t2_dr_gnt", dr_gnt, 1);
        chk("t2_gm_gnt", gm_gnt, 0);
        chk("t2_ram_addr", ram_addr, 33);
        chk("t2_dr_rvalid_early", dr_rvalid, 0);
        tick;
        dr_req = 1'b0;
        #1;
        chk("t2_dr_rvalid", dr_rvalid, 1);
        chk("t2_dr_rdata", dr_rdata, 1);
        chk("t2_gm_rvalid", gm_rvalid, 0);
        tick;
        chk("t2_dr_rvalid_pulse", dr_rvalid, 0);
        chk("t2_dr_rdata_hold", dr_rdata, 1);
        gm_req  = 1'b1;
        gm_addr = 10'd5;
        dr_req  = 1'b1;
        dr_addr = 10'd6;
        #1;
        chk("t3_gm_first", gm_gnt, 1);
        chk("t3_dr_wait", dr_gnt, 0);
        tick;
        gm_req = 1'b0;
        #1;
        chk("t3_dr_second", dr_gnt, 1);
        chk("t3_gm_rvalid", gm_rvalid, 1);
        chk("t3_gm_rdata", gm_rdata, 5);
        chk("t3_dr_no_xtalk", dr_rvalid, 0);
        tick;
        dr_req = 1'b0;
        #1;
        chk("t3_dr_rvalid", dr_rvalid, 1);
        chk("t3_dr_rdata", dr_rdata, 6);
        chk("t3_gm_no_xtalk", gm_rvalid, 0);
        chk("t3_gm_rdata_hold", gm_rdata, 5);
        tick;
        gm_req  = 1'b1;
        gm_addr = 10'd7;
        dr_req  = 1'b1;
        dr_addr = 10'd8;
        for (int k = 0; k < 9; k++) begin
            #1;
            pat[k] = dr_gnt;
            chk("t4_one_grant", gm_gnt, !dr_gnt);
            tick;
        end
        gm_req = 1'b0;
        dr_req = 1'b0;
        chk("t4_grant_pattern", pat, EXP_PAT);
        tick;
        chk("t4_gm_rdata", gm_rdata, 7);
        chk("t4_dr_rdata", dr_rdata, 0);
        gm_req   = 1'b1;
        gm_we    = 1'b1;
        gm_addr  = 10'd100;
        gm_wdata = 3'd7;
        #1;
        chk("t5_wr_gnt", gm_gnt, 1);
        chk("t5_ram_we", ram_we, 1);
        chk("t5_ram_addr", ram_addr, 100);
        chk("t5_ram_wdata", ram_wdata, 7);
        tick;
        gm_we = 1'b0;
        #1;
        chk("t5_rd_gnt", gm_gnt, 1);
        chk("t5_rd_ram_we", ram_we, 0);
        chk("t5_wr_no_rvalid", gm_rvalid, 0);
        tick;
        gm_req = 1'b0;
        #1;
        chk("t5_rvalid", gm_rvalid, 1);
        chk("t5_rdata_new", gm_rdata, 7);
        tick;
        reload = 1'b1;
        #1;
        chk("t6_ready_before_reload", maze_ready, 1);
        tick;
        reload = 1'b0;
        #1;
        chk("t6_drain2_not_ready", maze_ready, 0);
        n = 0;
        while (n_start < 2 && n < 10) begin
            tick;
            n++;
        end
        chk("t6_ld_start_again", n_start, 2);
        reload = 1'b1;
        tick;
        reload  = 1'b0;
        ld_done = 1'b1;
        n = 0;
        while (!maze_ready && n < 10) begin
            tick;
            n++;
        end
        ld_done = 1'b0;
        chk("t6_reload_ready", maze_ready, 1);
        chk("t6_reload_ignored_in_load", n_start, 2);
        dr_req  = 1'b1;
        dr_addr = 10'd33;
        #1;
        chk("t6_dr_gnt", dr_gnt, 1);
        tick;
        dr_req = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t6_dropped_rvalid", dr_rvalid, 0);
        tick;
        chk("t6_rst_dr_rvalid", dr_rvalid, 0);
        chk("t6_rst_gm_rdata", gm_rdata, 0);
        chk("t6_rst_ready", maze_ready, 0);
        chk("t6_rst_ld_start", ld_start, 0);
        chk("t6_rst_ram_we", ram_we, 0);
        resetn = 1'b1;
        bad = 0;
        repeat (3) begin
            tick;
            if (dr_rvalid || gm_rvalid) bad++;
        end
        chk("t6_no_late_rvalid", bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
